// File: rtl/kernel_cc_start_token_issuer_if.sv
// rtl/kernel_cc_start_token_issuer_if.sv - write-side bundle towards the kernel_cc start-token FIFOs
interface kernel_cc_start_token_issuer_if #(
  parameter int NUM_OUT    = 2,
  parameter int DATA_WIDTH = 1
);
  logic [NUM_OUT-1:0]            if_full_n;
  logic [NUM_OUT-1:0]            if_write;
  logic [NUM_OUT-1:0]            if_write_ce;
  logic [NUM_OUT*DATA_WIDTH-1:0] if_din;

  modport master (input if_full_n, output if_write, output if_write_ce, output if_din);
  modport slave  (output if_full_n, input if_write, input if_write_ce, input if_din);
endinterface

// File: rtl/kernel_cc_start_token_issuer.sv
// rtl/kernel_cc_start_token_issuer.sv - fans one ap_start request out as a token to NUM_OUT start FIFOs
// Optional stall counter output enabled by KERNEL_CC_START_STALL_CNT_EN.
module kernel_cc_start_token_issuer #(
  parameter int NUM_OUT    = 2,
  parameter int DATA_WIDTH = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ap_start,
  input  logic [DATA_WIDTH-1:0] ap_token,
  output logic                  ap_ready,
  output logic                  ap_idle,
  kernel_cc_start_token_issuer_if.master fifo,
  output logic [CNT_WIDTH-1:0]  tokens_issued
`ifdef KERNEL_CC_START_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                state;
  logic [NUM_OUT-1:0]    sent;
  logic [DATA_WIDTH-1:0] tok_q;
  logic [NUM_OUT-1:0]    accept;
  logic                  done;

  // Strobes derive only from registered state, so an async reset drops them at once.
  assign fifo.if_write    = (state == ISSUE) ? ~sent : '0;
  assign fifo.if_write_ce = fifo.if_write;
  assign fifo.if_din      = {NUM_OUT{tok_q}};

  assign accept   = fifo.if_write & fifo.if_full_n;
  assign done     = (state == ISSUE) && (&(sent | accept));
  assign ap_ready = done;
  assign ap_idle  = (state == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      sent          <= '0;
      tok_q         <= '0;
      tokens_issued <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ap_start) begin
            tok_q <= ap_token;
            sent  <= '0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (done) begin
            sent          <= '0;
            state         <= IDLE;
            tokens_issued <= tokens_issued + CNT_WIDTH'(1);
          end else begin
            sent <= sent | accept;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef KERNEL_CC_START_STALL_CNT_EN
  logic stalled;

  assign stalled = (state == ISSUE) && (|(fifo.if_write & ~fifo.if_full_n));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stalled && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_kernel_cc_start_token_issuer.sv
// tb/tb_kernel_cc_start_token_issuer.sv - randomized self-checking bench for kernel_cc_start_token_issuer
module tb_kernel_cc_start_token_issuer;
  localparam int N  = 2;
  localparam int DW = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          ap_start, ap_start2;
  logic [DW-1:0] ap_token;
  logic          ap_ready, ap_idle, ap_ready2, ap_idle2;
  logic [15:0]   tokens_issued;
  logic [1:0]    tokens_issued2;
`ifdef KERNEL_CC_START_STALL_CNT_EN
  logic [31:0]   stall_cycles, stall_cycles2;
  int            stall_exp;
`endif

  kernel_cc_start_token_issuer_if #(.NUM_OUT(N), .DATA_WIDTH(DW)) bus ();
  kernel_cc_start_token_issuer_if #(.NUM_OUT(N), .DATA_WIDTH(DW)) bus2 ();

  kernel_cc_start_token_issuer #(.NUM_OUT(N), .DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .ap_start(ap_start), .ap_token(ap_token),
    .ap_ready(ap_ready), .ap_idle(ap_idle), .fifo(bus.master), .tokens_issued(tokens_issued)
`ifdef KERNEL_CC_START_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  kernel_cc_start_token_issuer #(.NUM_OUT(N), .DATA_WIDTH(DW), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .ap_start(ap_start2), .ap_token(ap_token),
    .ap_ready(ap_ready2), .ap_idle(ap_idle2), .fifo(bus2.master), .tokens_issued(tokens_issued2)
`ifdef KERNEL_CC_START_STALL_CNT_EN
    , .stall_cycles(stall_cycles2)
`endif
  );

  always #5 clk = ~clk;

  int compares = 0;
  int errors   = 0;
  int issued   = 0;
  int kk [N];
  bit noise;
  int fcnt [N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compares++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Channel i first sees room in ISSUE cycle kk[i]; the request completes at the latest such cycle.
  task automatic run_request(input logic [DW-1:0] tok);
    int kmax;
    logic [N-1:0] fn, wexp;
    kmax = 0;
    for (int i = 0; i < N; i++) if (kk[i] > kmax) kmax = kk[i];
    ap_start = 1'b1;
    ap_token = tok;
    bus.if_full_n = N'($urandom);
    #1;
    check("idle_before", ap_idle, 1);
    check("no_write_idle", bus.if_write, 0);
    step();
    ap_token = ~tok;
    for (int j = 0; j <= kmax; j++) begin
      ap_start = 1'($urandom);
      for (int i = 0; i < N; i++) begin
        if (j < kk[i])       fn[i] = 1'b0;
        else if (j == kk[i]) fn[i] = 1'b1;
        else                 fn[i] = noise ? 1'($urandom) : 1'b1;
        wexp[i] = (j <= kk[i]);
      end
      bus.if_full_n = fn;
      #1;
      check("if_write", bus.if_write, wexp);
      check("if_write_ce", bus.if_write_ce, wexp);
      check("if_din", bus.if_din, {N{tok}});
      check("ap_ready", ap_ready, (j == kmax));
      check("ap_idle_issue", ap_idle, 0);
      step();
    end
    ap_start = 1'b0;
    issued++;
`ifdef KERNEL_CC_START_STALL_CNT_EN
    stall_exp += kmax;
    check("stall_cycles", stall_cycles, stall_exp);
`endif
    check("tokens_issued", tokens_issued, issued % 65536);
    check("idle_after", ap_idle, 1);
  endtask

  initial begin
    int done_cnt;
    reset = 1'b1;
    ap_start = 1'b0;
    ap_start2 = 1'b0;
    ap_token = '0;
    bus.if_full_n = '1;
    bus2.if_full_n = '1;
    noise = 1'b0;
`ifdef KERNEL_CC_START_STALL_CNT_EN
    stall_exp = 0;
`endif
    step();
    step();
    check("rst_idle", ap_idle, 1);
    check("rst_write", bus.if_write, 0);
    check("rst_ready", ap_ready, 0);
    check("rst_tokens", tokens_issued, 0);
    reset = 1'b0;
    step();

    kk[0] = 0; kk[1] = 0;
    run_request(1'b1);
    kk[0] = 0; kk[1] = 3;
    run_request(1'b1);
    kk[0] = 0; kk[1] = 7;
    run_request(1'b0);

    noise = 1'b1;
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++) kk[i] = $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0) begin
        bus.if_full_n = N'($urandom);
        #1;
        check("gap_write", bus.if_write, 0);
        step();
        check("gap_idle", ap_idle, 1);
      end
      run_request(DW'($urandom));
    end

    // Depth-4 FIFO environment with no reads: four requests fit, the fifth stalls.
    fcnt[0] = 0; fcnt[1] = 0;
    done_cnt = 0;
    ap_start = 1'b1;
    ap_token = 1'b1;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) bus.if_full_n[i] = (fcnt[i] < 4);
      #1;
      if (ap_ready) done_cnt++;
      for (int i = 0; i < N; i++) if (bus.if_write[i] && bus.if_full_n[i]) fcnt[i]++;
      step();
    end
    check("fifo_done4", done_cnt, 4);
    issued += 4;
    step();
    ap_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < N; i++) bus.if_full_n[i] = (fcnt[i] < 4);
      #1;
      check("fifo_stall_write", bus.if_write, 2'b11);
      check("fifo_stall_ready", ap_ready, 0);
      step();
    end
    for (int i = 0; i < N; i++) fcnt[i]--;
    for (int i = 0; i < N; i++) bus.if_full_n[i] = (fcnt[i] < 4);
    #1;
    check("fifo_5th_ready", ap_ready, 1);
    for (int i = 0; i < N; i++) if (bus.if_write[i] && bus.if_full_n[i]) fcnt[i]++;
    step();
    issued++;
    check("fifo0_level", fcnt[0], 4);
    check("fifo1_level", fcnt[1], 4);
    check("fifo_tokens", tokens_issued, issued % 65536);
`ifdef KERNEL_CC_START_STALL_CNT_EN
    stall_exp += 3;
    check("fifo_stall_cycles", stall_cycles, stall_exp);
`endif

    // Abort mid-ISSUE after FIFO0 has taken its token.
    ap_start = 1'b1;
    ap_token = 1'b1;
    step();
    ap_start = 1'b0;
    bus.if_full_n = 2'b01;
    #1;
    check("abort_first_write", bus.if_write, 2'b11);
    step();
    bus.if_full_n = 2'b00;
    #1;
    check("abort_retry_write", bus.if_write, 2'b10);
    reset = 1'b1;
    #1;
    check("abort_write", bus.if_write, 0);
    check("abort_idle", ap_idle, 1);
    check("abort_ready", ap_ready, 0);
    check("abort_tokens", tokens_issued, 0);
    step();
    reset = 1'b0;
    issued = 0;
`ifdef KERNEL_CC_START_STALL_CNT_EN
    stall_exp = 0;
    check("abort_stall", stall_cycles, 0);
`endif
    step();
    check("post_reset_idle", ap_idle, 1);
    check("post_reset_ready", ap_ready, 0);

    // Two-bit counter wraps 1,2,3,0,1.
    for (int r = 1; r <= 5; r++) begin
      ap_start2 = 1'b1;
      step();
      ap_start2 = 1'b0;
      #1;
      check("cnt2_ready", ap_ready2, 1);
      step();
      check("cnt2_tokens", tokens_issued2, r % 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end
endmodule
